// File: rtl/output_sched_pkg.sv
// Shared types and defaults for the per-output-port frame scheduler.
package output_sched_pkg;

   localparam int unsigned PORT_NUB_TOTAL = 4;
   localparam int unsigned WIDTH_DATA_DEF = 64;
   localparam int unsigned WIDTH_ADDR_DEF = 10;
   localparam int unsigned WIDTH_LEN_DEF  = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DESC,
      ST_READ,
      ST_DRAIN
   } sched_state_t;

   typedef logic [1:0] skid_cnt_t;

   // Skid slots that will be occupied once everything in flight lands,
   // crediting a word leaving this cycle so back-to-back reads keep flowing.
   function automatic logic [2:0] skid_occupancy(input skid_cnt_t count,
                                                 input logic      inflight,
                                                 input logic      pop);
      return 3'(count) + 3'(inflight) - 3'(pop);
   endfunction

endpackage

// File: rtl/output_sched_out_skid.sv
// 2-entry FIFO that absorbs the 1-cycle cache read latency against data_ready.
module out_skid
   import output_sched_pkg::*;
#(
   parameter int unsigned WIDTH = 66
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output skid_cnt_t        o_count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   skid_cnt_t        r_count;
   logic             w_pop;

   assign w_pop   = i_pop & (r_count != '0);
   assign o_valid = (r_count != '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + skid_cnt_t'(i_push) - skid_cnt_t'(w_pop);
      end
   end

endmodule

// File: rtl/output_sched.sv
// Per-output-port frame scheduler: grant -> descriptor -> cache reads -> stream -> free.
module output_sched
   import output_sched_pkg::*;
#(
   parameter  int unsigned NUB        = 0,
   parameter  int unsigned PORT_NUB   = PORT_NUB_TOTAL,
   parameter  int unsigned WIDTH_DATA = WIDTH_DATA_DEF,
   parameter  int unsigned WIDTH_ADDR = WIDTH_ADDR_DEF,
   parameter  int unsigned WIDTH_LEN  = WIDTH_LEN_DEF,
   localparam int unsigned WIDTH_SEL  = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH_SEL-1:0]  grant_port,
   input  logic                  grant_valid,
   output logic                  wrr_en,
   output logic [PORT_NUB-1:0]   desc_rd,
   input  logic                  desc_valid,
   input  logic [WIDTH_ADDR-1:0] desc_addr,
   input  logic [WIDTH_LEN-1:0]  desc_len,
   output logic                  cache_rd_en,
   output logic [WIDTH_ADDR-1:0] cache_rd_addr,
   input  logic [WIDTH_DATA-1:0] cache_rd_data,
   output logic [WIDTH_DATA-1:0] data_out,
   output logic                  data_valid,
   output logic                  data_sop,
   output logic                  data_eop,
   input  logic                  data_ready,
   output logic                  free_valid,
   output logic [WIDTH_ADDR-1:0] free_addr,
   output logic [WIDTH_LEN-1:0]  free_len
);

   sched_state_t          r_state;
   sched_state_t          w_state_nxt;
   logic [WIDTH_ADDR-1:0] r_addr;
   logic [WIDTH_ADDR-1:0] r_start;
   logic [WIDTH_LEN-1:0]  r_len;
   logic [WIDTH_LEN-1:0]  r_issued;
   logic [WIDTH_LEN-1:0]  w_issued_inc;
   logic                  r_inflight;
   logic                  r_inf_sop;
   logic                  r_inf_eop;
   logic                  r_free_valid;
   logic [WIDTH_ADDR-1:0] r_free_addr;
   logic [WIDTH_LEN-1:0]  r_free_len;
   logic                  w_pop;
   logic                  w_sk_valid;
   logic [WIDTH_DATA+1:0] w_sk_word;
   skid_cnt_t             w_sk_count;
   logic [2:0]            w_occ;
   logic                  w_self_grant;

   assign w_issued_inc  = r_issued + WIDTH_LEN'(1);
   assign w_pop         = w_sk_valid & data_ready;
   assign w_occ         = skid_occupancy(w_sk_count, r_inflight, w_pop);
   // The arbiter never grants our own port; treat one as noise rather than pop a queue.
   assign w_self_grant  = (grant_port == WIDTH_SEL'(NUB));

   assign cache_rd_addr = r_addr;
   assign data_valid    = w_sk_valid;
   assign data_sop      = w_sk_word[WIDTH_DATA+1];
   assign data_eop      = w_sk_word[WIDTH_DATA];
   assign data_out      = w_sk_word[WIDTH_DATA-1:0];
   assign free_valid    = r_free_valid;
   assign free_addr     = r_free_addr;
   assign free_len      = r_free_len;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and strobe outputs.
   always_comb begin
      w_state_nxt = r_state;
      wrr_en      = 1'b0;
      desc_rd     = '0;
      cache_rd_en = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // r_free_valid high means the previous frame is releasing this cycle.
            if (grant_valid && !r_free_valid && !w_self_grant) begin
               wrr_en              = 1'b1;
               desc_rd[grant_port] = 1'b1;
               w_state_nxt         = ST_DESC;
            end
         end
         ST_DESC: begin
            if (desc_valid) begin
               w_state_nxt = (desc_len == '0) ? ST_IDLE : ST_READ;
            end
         end
         ST_READ: begin
            if (w_occ < 3'd2) begin
               cache_rd_en = 1'b1;
               if (w_issued_inc == r_len) begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (w_pop && data_eop) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Descriptor latch, read address/count, in-flight tag and free-return register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr       <= '0;
         r_start      <= '0;
         r_len        <= '0;
         r_issued     <= '0;
         r_inflight   <= 1'b0;
         r_inf_sop    <= 1'b0;
         r_inf_eop    <= 1'b0;
         r_free_valid <= 1'b0;
         r_free_addr  <= '0;
         r_free_len   <= '0;
      end else begin
         r_free_valid <= 1'b0;
         r_inflight   <= cache_rd_en;
         r_inf_sop    <= (r_issued == '0);
         r_inf_eop    <= (w_issued_inc == r_len);
         if (r_state == ST_DESC && desc_valid) begin
            r_addr   <= desc_addr;
            r_start  <= desc_addr;
            r_len    <= desc_len;
            r_issued <= '0;
         end
         if (cache_rd_en) begin
            r_addr   <= r_addr + WIDTH_ADDR'(1);
            r_issued <= w_issued_inc;
         end
         if (r_state == ST_DRAIN && w_pop && data_eop) begin
            r_free_valid <= 1'b1;
            r_free_addr  <= r_start;
            r_free_len   <= r_len;
         end
      end
   end

   out_skid #(
      .WIDTH(WIDTH_DATA + 2)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_inflight),
      .i_data  ({r_inf_sop, r_inf_eop, cache_rd_data}),
      .i_pop   (w_pop),
      .o_valid (w_sk_valid),
      .o_data  (w_sk_word),
      .o_count (w_sk_count)
   );

endmodule

// File: tb/tb_output_sched.sv
// Scoreboard bench for output_sched: expected reads, words and frees are queued
// when a frame is launched and consumed as the DUT produces them.
module tb_output_sched;

   typedef struct {
      logic [63:0] d;
      logic        sop;
      logic        eop;
   } word_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  grant_port;
   logic        grant_valid;
   logic        wrr_en;
   logic [3:0]  desc_rd;
   logic        desc_valid;
   logic [9:0]  desc_addr;
   logic [5:0]  desc_len;
   logic        cache_rd_en;
   logic [9:0]  cache_rd_addr;
   logic [63:0] cache_rd_data;
   logic [63:0] data_out;
   logic        data_valid;
   logic        data_sop;
   logic        data_eop;
   logic        data_ready;
   logic        free_valid;
   logic [9:0]  free_addr;
   logic [5:0]  free_len;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          grant_cyc = 0;
   int          wrr_cnt  = 0;
   int          rmode    = 0;
   bit          lat_on   = 0;
   bit          busy     = 0;
   bit          desc_pend = 0;
   bit          free_expect_next = 0;
   bit          prev_stall = 0;
   logic [63:0] prev_d;
   logic [1:0]  prev_flags;
   logic [3:0]  exp_desc_rd;
   logic [9:0]  t_addr;
   logic [5:0]  t_len;

   logic [9:0]  q_rd [$];
   word_t       q_exp [$];
   logic [15:0] q_free [$];

   output_sched #(
      .NUB        (0),
      .PORT_NUB   (4),
      .WIDTH_DATA (64),
      .WIDTH_ADDR (10),
      .WIDTH_LEN  (6)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .grant_port    (grant_port),
      .grant_valid   (grant_valid),
      .wrr_en        (wrr_en),
      .desc_rd       (desc_rd),
      .desc_valid    (desc_valid),
      .desc_addr     (desc_addr),
      .desc_len      (desc_len),
      .cache_rd_en   (cache_rd_en),
      .cache_rd_addr (cache_rd_addr),
      .cache_rd_data (cache_rd_data),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .data_sop      (data_sop),
      .data_eop      (data_eop),
      .data_ready    (data_ready),
      .free_valid    (free_valid),
      .free_addr     (free_addr),
      .free_len      (free_len)
   );

   function automatic logic [63:0] mem_f(input logic [9:0] a);
      return {16'hCAFE, 6'h15, a, 22'h2AB0F1, ~a};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle-latency shared cache model.
   always @(posedge clk) begin
      if (cache_rd_en) cache_rd_data <= mem_f(cache_rd_addr);
   end

   // Descriptor queue responder: answers the cycle after desc_rd.
   initial begin
      desc_valid = 0; desc_addr = '0; desc_len = '0;
      forever begin
         @(posedge clk); #1;
         desc_valid = 0;
         if (desc_pend) begin
            desc_pend  = 0;
            desc_valid = 1;
            desc_addr  = t_addr;
            desc_len   = t_len;
         end
      end
   end

   // Downstream ready pattern.
   initial begin
      data_ready = 1;
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0: data_ready = 1;
            1: data_ready = (cyc % 3 == 0);
            2: data_ready = 0;
            default: data_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Output monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall       = 0;
         free_expect_next = 0;
      end else begin
         if (wrr_en) begin
            check("wrr_while_busy", 64'(busy), 0);
            check("desc_rd", 64'(desc_rd), 64'(exp_desc_rd));
            busy = 1;
            wrr_cnt++;
            grant_cyc = cyc;
            desc_pend = 1;
         end else if (desc_rd != 0) begin
            check("desc_rd_no_wrr", 64'(desc_rd), 0);
         end
         if (cache_rd_en) begin
            if (q_rd.size() != 0) check("rd_addr", 64'(cache_rd_addr), 64'(q_rd.pop_front()));
            else check("rd_expected", 64'(q_rd.size()), 1);
         end
         if (prev_stall) begin
            check("hold_valid", 64'(data_valid), 1);
            check("hold_data", data_out, prev_d);
            check("hold_flags", 64'({data_sop, data_eop}), 64'(prev_flags));
         end
         if (data_valid && data_ready) begin
            if (q_exp.size() != 0) begin
               word_t w;
               w = q_exp.pop_front();
               check("data", data_out, w.d);
               check("sop", 64'(data_sop), 64'(w.sop));
               check("eop", 64'(data_eop), 64'(w.eop));
               if (lat_on && data_sop) begin
                  check("latency", 64'(cyc - grant_cyc), 4);
                  lat_on = 0;
               end
            end else begin
               check("word_expected", 64'(q_exp.size()), 1);
            end
         end
         if (free_expect_next || free_valid)
            check("free_timing", 64'(free_valid), 64'(free_expect_next));
         if (free_valid) begin
            if (q_free.size() != 0) check("free", 64'({free_addr, free_len}), 64'(q_free.pop_front()));
            else check("free_expected", 64'(q_free.size()), 1);
            busy = 0;
         end
         free_expect_next = data_valid && data_ready && data_eop;
         prev_stall = data_valid && !data_ready;
         prev_d     = data_out;
         prev_flags = {data_sop, data_eop};
      end
   end

   task automatic load_frame(input logic [1:0] port, input logic [9:0] addr, input logic [5:0] len);
      logic [9:0] ra;
      word_t      w;
      t_addr      = addr;
      t_len       = len;
      exp_desc_rd = 4'b0001 << port;
      for (int i = 0; i < int'(len); i++) begin
         ra    = addr + 10'(i);
         q_rd.push_back(ra);
         w.d   = mem_f(ra);
         w.sop = (i == 0);
         w.eop = (i == int'(len) - 1);
         q_exp.push_back(w);
      end
      if (len != 0) q_free.push_back({addr, len});
   endtask

   task automatic run_frame(input logic [1:0] port, input logic [9:0] addr, input logic [5:0] len,
                            input int mode, input bit hold);
      int k;
      int wrr_before;
      wrr_before = wrr_cnt;
      rmode = mode;
      load_frame(port, addr, len);
      @(posedge clk); #1;
      grant_port  = port;
      grant_valid = 1;
      if (!hold) begin
         @(posedge clk); #1;
         grant_valid = 0;
      end
      k = 0;
      while ((q_exp.size() != 0 || q_free.size() != 0 || q_rd.size() != 0) && k < 400) begin
         @(posedge clk); #1;
         if (hold && q_free.size() == 0) grant_valid = 0;
         k++;
      end
      grant_valid = 0;
      check("frame_done_in_budget", 64'(k < 400), 1);
      repeat (8) @(posedge clk);
      check("wrr_pulses", 64'(wrr_cnt - wrr_before), 1);
      busy = 0;
      rmode = 0;
   endtask

   initial begin
      int k;
      rst_n = 0; grant_port = '0; grant_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", 64'({wrr_en, desc_rd, cache_rd_en, data_valid, data_sop, data_eop, free_valid}), 0);
      check("rst_data", data_out, 0);
      check("rst_addr", 64'({cache_rd_addr, free_addr, free_len}), 0);
      @(posedge clk); #1;
      rst_n = 1;
      repeat (2) @(posedge clk);

      lat_on = 1;
      run_frame(2'd2, 10'h010, 6'd4, 0, 0);
      run_frame(2'd1, 10'h100, 6'd1, 0, 0);
      run_frame(2'd3, 10'h200, 6'd0, 0, 0);
      run_frame(2'd2, 10'h3FE, 6'd4, 0, 0);
      run_frame(2'd2, 10'h040, 6'd8, 1, 1);

      // Reset in the middle of a stalled READ.
      rmode = 2;
      load_frame(2'd3, 10'h0C0, 6'd8);
      @(posedge clk); #1;
      grant_port = 2'd3; grant_valid = 1;
      @(posedge clk); #1;
      grant_valid = 0;
      k = 0;
      while (q_rd.size() > 6 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("reads_before_reset", 64'(q_rd.size()), 6);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      check("abort_ctl", 64'({wrr_en, desc_rd, cache_rd_en, data_valid, data_sop, data_eop, free_valid}), 0);
      check("abort_data", data_out, 0);
      check("abort_addr", 64'({cache_rd_addr, free_addr, free_len}), 0);
      q_rd.delete(); q_exp.delete(); q_free.delete();
      busy = 0; desc_pend = 0; rmode = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      repeat (2) @(posedge clk);
      run_frame(2'd1, 10'h080, 6'd3, 0, 0);
      run_frame(2'd1, 10'h3F0, 6'd20, 3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
